line_buffer_ctrl: RTL and testbench

Sequencer for the convolver's 3x3 line buffer. It clears the buffer at frame start and gates the `shifting` strobe with a valid/ready pixel handshake. It tracks the row/column position of every pixel pushed in and raises a window-valid handshake toward the MAC array whenever the nine line-buffer taps hold a complete 3x3 window. It sits between the feature-map read path and the line buffer plus convolution datapath.

---
 rtl/line_buffer_ctrl.sv | 122 ++++++++++++
 tb/tb_line_buffer_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: frame sequencer for the convolver's 3x3 line buffer.
// Clears the buffer, gates pixel shifts and flags each complete window with its coordinates.
`ifndef ADDR_FIFO
`define ADDR_FIFO 10
`endif

module line_buffer_ctrl #(
    parameter int COL_W = `ADDR_FIFO,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [COL_W-1:0] row_length,
    input  logic [ROW_W-1:0] num_rows,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             shifting,
    output logic             line_buffer_reset,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [ROW_W-1:0] win_row,
    output logic [COL_W-1:0] win_col,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic [COL_W-1:0] row_len_q, col_q;
    logic [ROW_W-1:0] num_rows_q, row_q;
    logic             cfg_ok, start_ok, start_bad;
    logic             last_pix, win_hit;

    assign shifting = pix_valid & pix_ready;
    assign last_pix = (row_q == num_rows_q - ROW_W'(1)) && (col_q == row_len_q - COL_W'(1));
    // Only pixels at column >= 2 close a window, so no window straddles two rows.
    assign win_hit  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    always_comb begin
        state_next = state;
        pix_ready  = 1'b0;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        cfg_ok     = (row_length >= COL_W'(3)) && (num_rows >= ROW_W'(3));
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        start_ok   = 1'b1;
                        state_next = CLEAR;
                    end else begin
                        start_bad  = 1'b1;
                    end
                end
            end
            CLEAR: state_next = RUN;
            RUN: begin
                pix_ready = !win_valid || win_ready;
                if (pix_valid && pix_ready && last_pix)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (!win_valid)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            row_q             <= '0;
            col_q             <= '0;
            win_valid         <= 1'b0;
            win_row           <= '0;
            win_col           <= '0;
            line_buffer_reset <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            cfg_err           <= 1'b0;
        end else begin
            state             <= state_next;
            line_buffer_reset <= (state_next == CLEAR);
            busy              <= (state_next != IDLE);
            done              <= (state_next == DONE);
            cfg_err           <= start_bad;

            if (start_ok) begin
                row_q <= '0;
                col_q <= '0;
            end else if (shifting) begin
                if (col_q == row_len_q - COL_W'(1)) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end

            // A new window replaces a consumed one in the same cycle, without a bubble.
            if (shifting && win_hit) begin
                win_valid <= 1'b1;
                win_row   <= row_q - ROW_W'(2);
                win_col   <= col_q - COL_W'(2);
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    // Frame geometry is only meaningful after an accepted start.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            row_len_q  <= row_length;
            num_rows_q <= num_rows;
        end
    end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: self-checking bench for line_buffer_ctrl.
// Directed vector table, corner-case sequences and random frames against a pixel-index window model.
module tb_line_buffer_ctrl;
    localparam int COL_W = 10;
    localparam int ROW_W = 10;

    logic             clk = 1'b0;
    logic             rst, start, pix_valid, win_ready;
    logic [COL_W-1:0] row_length;
    logic [ROW_W-1:0] num_rows;
    logic             pix_ready, shifting, line_buffer_reset, win_valid, busy, done, cfg_err;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;

    line_buffer_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .clk(clk), .rst(rst), .start(start), .row_length(row_length), .num_rows(num_rows),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .shifting(shifting),
        .line_buffer_reset(line_buffer_reset), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc; bit pv; bit wrdy;
        bit lbr; bit pr; bit wv; int wrow; int wcol; bit dn; bit bsy;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int shift_cnt = 0, lbr_cnt = 0, done_cnt = 0, cfg_cnt = 0;
    int got_row[$];
    int got_col[$];
    int model_rl = 1, frame_k = 0;
    bit prev_rst = 1'b0, prev_shift = 1'b0, prev_wv = 1'b0, prev_wrdy = 1'b0;
    int prev_row = 0, prev_col = 0, prev_r = 0, prev_c = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({5'b0, pix_ready, shifting, line_buffer_reset, win_valid, busy, done,
                     cfg_err, win_row, win_col});
    endfunction

    // Reference: every accepted pixel has raster index k -> (k / row_length, k % row_length).
    task automatic observe();
        int ewv, erow, ecol;
        bit ccoord;
        chk("shift_eq_handshake", int'(shifting), int'(pix_valid & pix_ready));
        if (win_valid && !win_ready) chk("stall_blocks_ready", int'(pix_ready), 0);
        ccoord = 1'b1;
        if (!prev_rst) begin
            ewv = 0; erow = 0; ecol = 0;
        end else if (prev_shift && prev_r >= 2 && prev_c >= 2) begin
            ewv = 1; erow = prev_r - 2; ecol = prev_c - 2;
        end else begin
            ewv = int'(prev_wv && !prev_wrdy); erow = prev_row; ecol = prev_col;
            ccoord = (ewv != 0);
        end
        chk("model_win_valid", int'(win_valid), ewv);
        if (ccoord) begin
            chk("model_win_row", int'(win_row), erow);
            chk("model_win_col", int'(win_col), ecol);
        end
        prev_rst   = rst;
        prev_shift = shifting;
        prev_wv    = win_valid;
        prev_wrdy  = win_ready;
        prev_row   = int'(win_row);
        prev_col   = int'(win_col);
        if (shifting) begin
            prev_r = frame_k / model_rl;
            prev_c = frame_k % model_rl;
            frame_k++;
            shift_cnt++;
        end
        if (win_valid && win_ready) begin
            got_row.push_back(int'(win_row));
            got_col.push_back(int'(win_col));
        end
        lbr_cnt  += int'(line_buffer_reset);
        done_cnt += int'(done);
        cfg_cnt  += int'(cfg_err);
    endtask

    task automatic at_neg();
        @(negedge clk);
        observe();
    endtask

    task automatic to_next();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_frame(input int rl, input int nr);
        row_length = COL_W'(rl);
        num_rows   = ROW_W'(nr);
        model_rl   = rl;
        frame_k    = 0;
    endtask

    task automatic check_frame(input string name, input int sh0, input int w0, input int lb0,
                               input int rl, input int nr);
        int idx;
        chk({name, "_shifts"}, shift_cnt - sh0, rl * nr);
        chk({name, "_lbr_pulses"}, lbr_cnt - lb0, 1);
        chk({name, "_windows"}, got_row.size() - w0, (rl - 2) * (nr - 2));
        idx = w0;
        for (int r = 0; r <= nr - 3; r++) begin
            for (int c = 0; c <= rl - 3; c++) begin
                if (idx < got_row.size()) begin
                    chk({name, "_win_row"}, got_row[idx], r);
                    chk({name, "_win_col"}, got_col[idx], c);
                end
                idx++;
            end
        end
    endtask

    // mode 0: continuous, 1: stall win_ready 3 cycles at first window, 2: random handshakes.
    task automatic run_frame(input string name, input int rl, input int nr, input int mode,
                             input int inj, output int done_cyc);
        int sh0, w0, lb0, cf0, stall_left;
        bit stalled;
        sh0 = shift_cnt; w0 = got_row.size(); lb0 = lbr_cnt; cf0 = cfg_cnt;
        stall_left = 0; stalled = 1'b0; done_cyc = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            start = (cyc == 0) || (cyc == inj);
            if (cyc == 0) begin
                begin_frame(rl, nr);
            end else if (cyc == inj) begin
                row_length = COL_W'(3);
                num_rows   = ROW_W'(3);
            end
            pix_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 1 && win_valid && !stalled) begin
                stalled = 1'b1;
                stall_left = 3;
            end
            win_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : (stall_left == 0);
            at_neg();
            if (stall_left > 0) begin
                chk({name, "_stall_pix_ready"}, int'(pix_ready), 0);
                chk({name, "_stall_shifting"}, int'(shifting), 0);
                stall_left--;
            end
            if (done) begin
                done_cyc = cyc;
                to_next();
                break;
            end
            to_next();
        end
        start = 1'b0;
        chk({name, "_done_seen"}, int'(done_cyc >= 0), 1);
        check_frame(name, sh0, w0, lb0, rl, nr);
        chk({name, "_no_cfg_err"}, cfg_cnt - cf0, 0);
        at_neg();
        chk({name, "_idle_busy"}, int'(busy), 0);
        to_next();
    endtask

    task automatic cfg_reject(input int rl, input int nr);
        int sh0, c0;
        sh0 = shift_cnt; c0 = cfg_cnt;
        row_length = COL_W'(rl); num_rows = ROW_W'(nr);
        start = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
        at_neg();
        chk("cfg_err_not_yet", int'(cfg_err), 0);
        to_next();
        start = 1'b0;
        at_neg();
        chk("cfg_err_pulse", int'(cfg_err), 1);
        chk("cfg_busy", int'(busy), 0);
        chk("cfg_pix_ready", int'(pix_ready), 0);
        to_next();
        at_neg();
        chk("cfg_err_clears", int'(cfg_err), 0);
        chk("cfg_busy_after", int'(busy), 0);
        chk("cfg_lbr", int'(line_buffer_reset), 0);
        to_next();
        chk("cfg_no_shift", shift_cnt - sh0, 0);
        chk("cfg_err_count", cfg_cnt - c0, 1);
    endtask

    initial begin
        vec_t tbl [14];
        int   sh0, w0, lb0, d0, ti, dc;

        tbl[0]  = '{0,  1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1,  1, 1, 1, 0, 0, 0, 0, 0, 1};
        tbl[2]  = '{2,  1, 1, 0, 1, 0, 0, 0, 0, 1};
        tbl[3]  = '{14, 1, 1, 0, 1, 0, 0, 0, 0, 1};
        tbl[4]  = '{15, 1, 1, 0, 1, 1, 0, 0, 0, 1};
        tbl[5]  = '{16, 1, 1, 0, 1, 1, 0, 1, 0, 1};
        tbl[6]  = '{17, 1, 1, 0, 1, 1, 0, 2, 0, 1};
        tbl[7]  = '{18, 1, 1, 0, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{20, 1, 1, 0, 1, 1, 1, 0, 0, 1};
        tbl[9]  = '{21, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        tbl[10] = '{22, 1, 1, 0, 0, 1, 1, 2, 0, 1};
        tbl[11] = '{23, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{24, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        tbl[13] = '{25, 1, 1, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b0; start = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
        row_length = COL_W'(5); num_rows = ROW_W'(4);
        to_next();
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("reset_outputs", outs(), 0);
            to_next();
        end
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0;
        at_neg();
        chk("idle_outputs", outs(), 0);
        to_next();

        // Directed 5x4 frame with continuous flow, checked cycle by cycle from the table.
        sh0 = shift_cnt; w0 = got_row.size(); lb0 = lbr_cnt; d0 = done_cnt; ti = 0;
        for (int cyc = 0; cyc <= 25; cyc++) begin
            if (ti < 14 && tbl[ti].cyc == cyc) begin
                pix_valid = tbl[ti].pv;
                win_ready = tbl[ti].wrdy;
            end
            start = (cyc == 0);
            if (cyc == 0) begin_frame(5, 4);
            at_neg();
            if (ti < 14 && tbl[ti].cyc == cyc) begin
                chk($sformatf("tbl_lbr_c%0d", cyc), int'(line_buffer_reset), int'(tbl[ti].lbr));
                chk($sformatf("tbl_pix_ready_c%0d", cyc), int'(pix_ready), int'(tbl[ti].pr));
                chk($sformatf("tbl_win_valid_c%0d", cyc), int'(win_valid), int'(tbl[ti].wv));
                chk($sformatf("tbl_done_c%0d", cyc), int'(done), int'(tbl[ti].dn));
                chk($sformatf("tbl_busy_c%0d", cyc), int'(busy), int'(tbl[ti].bsy));
                if (tbl[ti].wv) begin
                    chk($sformatf("tbl_win_row_c%0d", cyc), int'(win_row), tbl[ti].wrow);
                    chk($sformatf("tbl_win_col_c%0d", cyc), int'(win_col), tbl[ti].wcol);
                end
                ti++;
            end
            to_next();
        end
        check_frame("t1", sh0, w0, lb0, 5, 4);
        chk("t1_done_pulses", done_cnt - d0, 1);

        run_frame("stall", 5, 4, 1, -1, dc);
        chk("stall_done_cycle", dc, 27);
        run_frame("min3x3", 3, 3, 0, -1, dc);
        chk("min3x3_done_cycle", dc, 13);
        run_frame("start_in_run", 5, 4, 0, 6, dc);
        chk("start_in_run_done_cycle", dc, 24);

        cfg_reject(2, 4);
        cfg_reject(5, 2);

        for (int i = 0; i < 3; i++) run_frame("rand4x3", 4, 3, 2, -1, dc);
        for (int i = 0; i < 4; i++)
            run_frame("rand_cfg", int'($urandom_range(3, 7)), int'($urandom_range(3, 6)), 2, -1, dc);

        // Reset in the middle of RUN, then a clean frame.
        sh0 = shift_cnt;
        begin_frame(5, 4);
        start = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
        at_neg();
        to_next();
        start = 1'b0;
        for (int i = 0; i < 100 && (shift_cnt - sh0) < 7; i++) begin
            at_neg();
            to_next();
        end
        chk("midrun_shifts_before_reset", shift_cnt - sh0, 7);
        rst = 1'b0;
        at_neg();
        to_next();
        rst = 1'b1;
        at_neg();
        chk("midrun_reset_outputs", outs(), 0);
        to_next();
        run_frame("post_reset", 5, 4, 0, -1, dc);
        chk("post_reset_done_cycle", dc, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
